// File: rtl/uart_arbiter_pkg.sv
// Shared encodings for the UART ownership arbiter.
package uart_arbiter_pkg;

  localparam int CPU_NUM_W       = 2;
  localparam int CPU_SEL_W       = 3;
  localparam int ARB_TIMEOUT_DEF = 4096;

  // Select code that routes no CPU onto the UART.
  localparam logic [CPU_NUM_W-1:0] UART_NO_CPU = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SETTLE  = 2'd1,
    ARB_OWN     = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  // Next CPU index in round-robin order, wrapping 2 -> 0.
  function automatic logic [CPU_NUM_W-1:0] rr_next(input logic [CPU_NUM_W-1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, last (mod 3).
module uart_rr_pick
  import uart_arbiter_pkg::*;
(
  input  logic [2:0] eligible,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] base;
  logic [1:0] cand0;
  logic [1:0] cand1;

  // An out-of-range last (3) behaves as 2 so CPU0 is searched first.
  always_comb begin
    base   = (last > 2'd2) ? 2'd2 : last;
    cand0  = rr_next(base);
    cand1  = rr_next(cand0);
    valid  = |eligible;
    winner = base;
    if (eligible[cand0]) begin
      winner = cand0;
    end else if (eligible[cand1]) begin
      winner = cand1;
    end
  end

endmodule

// File: rtl/uart_arbiter.sv
// Round-robin UART ownership arbiter with idle-timeout watchdog.
module uart_arbiter
  import uart_arbiter_pkg::*;
#(
  parameter int NUM_CPU = 3,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF,
  parameter int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CPU-1:0] cpu_req,
  input  logic [NUM_CPU-1:0] cpu_acc,
  output logic [NUM_CPU-1:0] cpu_gnt,
  output logic [1:0]         cpu_uart_num,
  output logic               arb_busy,
  output logic               timeout_pulse,
  output logic [1:0]         timeout_cpu
);

  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [NUM_CPU-1:0] ban_q, ban_d;
  logic [NUM_CPU-1:0] gnt_q, gnt_d;
  logic [1:0]         num_q, num_d;
  logic               pulse_q, pulse_d;
  logic [1:0]         tcpu_q, tcpu_d;
  logic               busy_q, busy_d;

  logic [NUM_CPU-1:0] eligible;
  logic               pick_valid;
  logic [1:0]         pick_winner;

  // A CPU banned by the watchdog stays out until it drops its request.
  assign eligible = cpu_req & ~ban_q;

  uart_rr_pick u_pick (
    .eligible (eligible),
    .last     (last_q),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  // Next-state and registered-output logic for the ownership FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    idle_cnt_d = idle_cnt_q;
    ban_d      = ban_q & cpu_req;
    gnt_d      = gnt_q;
    num_d      = num_q;
    pulse_d    = 1'b0;
    tcpu_d     = tcpu_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          num_d   = pick_winner;
          state_d = ARB_SETTLE;
        end
      end
      ARB_SETTLE: begin
        // The mux has registered the select by now, so the grant is safe.
        gnt_d      = NUM_CPU'(1) << owner_q;
        idle_cnt_d = '0;
        state_d    = ARB_OWN;
      end
      ARB_OWN: begin
        if (!cpu_req[owner_q]) begin
          // A voluntary drop takes precedence over a coincident timeout.
          state_d = ARB_RELEASE;
          gnt_d   = '0;
          num_d   = UART_NO_CPU;
          last_d  = owner_q;
        end else if (cpu_acc[owner_q]) begin
          idle_cnt_d = '0;
        end else if (TO_EN && (idle_cnt_q == CNT_LAST)) begin
          state_d        = ARB_RELEASE;
          gnt_d          = '0;
          num_d          = UART_NO_CPU;
          last_d         = owner_q;
          pulse_d        = 1'b1;
          tcpu_d         = owner_q;
          ban_d[owner_q] = 1'b1;
        end else if (idle_cnt_q != CNT_SAT) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers; reset drops any grant at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= 2'd0;
      last_q     <= 2'd2;
      idle_cnt_q <= '0;
      ban_q      <= '0;
      gnt_q      <= '0;
      num_q      <= UART_NO_CPU;
      pulse_q    <= 1'b0;
      tcpu_q     <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      idle_cnt_q <= idle_cnt_d;
      ban_q      <= ban_d;
      gnt_q      <= gnt_d;
      num_q      <= num_d;
      pulse_q    <= pulse_d;
      tcpu_q     <= tcpu_d;
      busy_q     <= busy_d;
    end
  end

  assign cpu_gnt       = gnt_q;
  assign cpu_uart_num  = num_q;
  assign arb_busy      = busy_q;
  assign timeout_pulse = pulse_q;
  assign timeout_cpu   = tcpu_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: per-cycle model comparison plus directed scenarios.
module tb_uart_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cpu_req = 3'b000;
  logic [2:0] cpu_acc = 3'b000;
  logic [2:0] cpu_gnt;
  logic [1:0] cpu_uart_num;
  logic       arb_busy;
  logic       timeout_pulse;
  logic [1:0] timeout_cpu;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  uart_arbiter #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_acc       (cpu_acc),
    .cpu_gnt       (cpu_gnt),
    .cpu_uart_num  (cpu_uart_num),
    .arb_busy      (arb_busy),
    .timeout_pulse (timeout_pulse),
    .timeout_cpu   (timeout_cpu)
  );

  always #5 clk = ~clk;

  // Phases: 0 idle, 1 select settling, 2 owned, 3 dead release cycle.
  typedef struct {
    int       ph;
    int       own;
    int       lst;
    int       icnt;
    int       tcpu;
    bit       pulse;
    bit [2:0] ban;
  } mstate_t;

  localparam mstate_t M_RST = '{ph: 0, own: 0, lst: 2, icnt: 0, tcpu: 0, pulse: 1'b0, ban: 3'b000};

  mstate_t m = M_RST;

  function automatic mstate_t model_step(mstate_t s, bit [2:0] r, bit [2:0] a);
    mstate_t  n   = s;
    bit [2:0] el  = r & ~s.ban;
    bit       got = 1'b0;
    n.pulse = 1'b0;
    n.ban   = s.ban & r;
    case (s.ph)
      0: begin
        for (int d = 1; d <= 3; d++) begin
          int c = (s.lst + d) % 3;
          if (!got && el[c]) begin
            got   = 1'b1;
            n.own = c;
            n.ph  = 1;
          end
        end
      end
      1: begin
        n.ph   = 2;
        n.icnt = 0;
      end
      2: begin
        if (!r[s.own]) begin
          n.ph  = 3;
          n.lst = s.own;
        end else if (a[s.own]) begin
          n.icnt = 0;
        end else if (s.icnt == TO - 1) begin
          n.ph         = 3;
          n.lst        = s.own;
          n.pulse      = 1'b1;
          n.tcpu       = s.own;
          n.ban[s.own] = 1'b1;
        end else begin
          n.icnt = (s.icnt < TO) ? s.icnt + 1 : TO;
        end
      end
      default: n.ph = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= M_RST;
    else      m <= model_step(m, cpu_req, cpu_acc);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model and the structural invariants.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      int gidx;
      gidx = (cpu_gnt == 3'b010) ? 1 : (cpu_gnt == 3'b100) ? 2 : 0;
      chk("cyc_gnt",   int'(cpu_gnt), (m.ph == 2) ? (1 << m.own) : 0);
      chk("cyc_num",   int'(cpu_uart_num), (m.ph == 1 || m.ph == 2) ? m.own : 3);
      chk("cyc_busy",  int'(arb_busy), int'(m.ph != 0));
      chk("cyc_pulse", int'(timeout_pulse), int'(m.pulse));
      chk("cyc_tcpu",  int'(timeout_cpu), m.tcpu);
      chk("inv_onehot", int'($onehot0(cpu_gnt)), 1);
      chk("inv_gnt_own", int'((cpu_gnt != 0) && (m.ph != 2)), 0);
      chk("inv_num_phase", int'((cpu_uart_num != 2'b11) && !(m.ph == 1 || m.ph == 2)), 0);
      chk("inv_num_owner", int'((cpu_gnt != 0) && (int'(cpu_uart_num) != gidx)), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst     = 1'b0;
    cpu_req = 3'b000;
    cpu_acc = 3'b000;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic wait_gnt(input int budget, output int waited);
    waited = 0;
    while (cpu_gnt == 3'b000 && waited < budget) begin
      tick();
      waited++;
    end
    chk("wait_gnt_bound", int'(cpu_gnt != 3'b000), 1);
  endtask

  initial begin
    int w;
    int bad;
    int exp_rr [4] = '{1, 2, 4, 1};

    // Reset state, checked while reset is held.
    #2 rst = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("rst_gnt",   int'(cpu_gnt), 0);
    chk("rst_num",   int'(cpu_uart_num), 3);
    chk("rst_busy",  int'(arb_busy), 0);
    chk("rst_pulse", int'(timeout_pulse), 0);
    chk("rst_tcpu",  int'(timeout_cpu), 0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Single request: select one cycle after the request, grant two.
    tick();
    cpu_req = 3'b010;
    tick();
    chk("single_num_n1", int'(cpu_uart_num), 1);
    chk("single_gnt_n1", int'(cpu_gnt), 0);
    tick();
    chk("single_gnt_n2", int'(cpu_gnt), 3'b010);
    chk("single_num_n2", int'(cpu_uart_num), 1);
    cpu_req = 3'b000;
    tick();
    chk("single_rel_gnt", int'(cpu_gnt), 0);
    chk("single_rel_num", int'(cpu_uart_num), 3);
    chk("single_rel_busy", int'(arb_busy), 1);
    tick();
    chk("single_idle_busy", int'(arb_busy), 0);

    // Round-robin with all three requesting; each owner holds 5 cycles.
    do_reset();
    cpu_req = 3'b111;
    wait_gnt(10, w);
    chk("rr_first", int'(cpu_gnt), exp_rr[0]);
    for (int k = 1; k < 4; k++) begin
      repeat (4) tick();
      cpu_req = 3'b111 & ~cpu_gnt;
      tick();
      chk("rr_rel_gnt", int'(cpu_gnt), 0);
      cpu_req = 3'b111;
      wait_gnt(10, w);
      // Zero-grant cycles after the drop: release, idle decision, settle.
      chk("rr_gap", w, 3);
      chk("rr_order", int'(cpu_gnt), exp_rr[k]);
    end

    // Watchdog: CPU2 owns without accessing and is forced off.
    do_reset();
    cpu_req = 3'b100;
    wait_gnt(10, w);
    chk("to_gnt", int'(cpu_gnt), 3'b100);
    repeat (7) tick();
    chk("to_not_yet", int'(timeout_pulse), 0);
    tick();
    chk("to_pulse", int'(timeout_pulse), 1);
    chk("to_cpu", int'(timeout_cpu), 2);
    chk("to_gnt_clr", int'(cpu_gnt), 0);
    cpu_req = 3'b101;
    tick();
    chk("to_pulse_once", int'(timeout_pulse), 0);
    chk("to_cpu_hold", int'(timeout_cpu), 2);
    wait_gnt(10, w);
    chk("to_cpu0_wins", int'(cpu_gnt), 3'b001);
    repeat (2) tick();
    cpu_req = 3'b100;
    bad = 0;
    repeat (10) begin
      tick();
      if (cpu_gnt != 3'b000) bad++;
    end
    chk("to_banned", bad, 0);
    cpu_req = 3'b000;
    tick();
    cpu_req = 3'b100;
    wait_gnt(10, w);
    chk("to_unbanned", int'(cpu_gnt), 3'b100);

    // Periodic owner accesses keep the watchdog quiet.
    do_reset();
    cpu_req = 3'b001;
    wait_gnt(10, w);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cpu_acc = (i % 7 == 6) ? 3'b001 : 3'b000;
      tick();
      if (timeout_pulse || cpu_gnt != 3'b001) bad++;
    end
    cpu_acc = 3'b000;
    chk("acc_hold", bad, 0);

    // Drop coinciding with the last idle cycle: drop wins, no pulse.
    do_reset();
    cpu_req = 3'b010;
    wait_gnt(10, w);
    repeat (7) tick();
    chk("sim_still_own", int'(cpu_gnt), 3'b010);
    cpu_req = 3'b000;
    tick();
    chk("sim_no_pulse", int'(timeout_pulse), 0);
    chk("sim_tcpu", int'(timeout_cpu), 0);
    chk("sim_gnt_clr", int'(cpu_gnt), 0);

    // Request dropped during settle: exactly one owned cycle.
    do_reset();
    cpu_req = 3'b001;
    tick();
    chk("settle_num", int'(cpu_uart_num), 0);
    cpu_req = 3'b000;
    tick();
    chk("settle_own", int'(cpu_gnt), 3'b001);
    tick();
    chk("settle_rel_gnt", int'(cpu_gnt), 0);
    chk("settle_rel_num", int'(cpu_uart_num), 3);
    tick();
    chk("settle_idle", int'(arb_busy), 0);

    // Asynchronous reset while owned drops the grant immediately.
    do_reset();
    cpu_req = 3'b010;
    wait_gnt(10, w);
    #2 rst = 1'b0;
    #1;
    chk("arst_gnt",  int'(cpu_gnt), 0);
    chk("arst_num",  int'(cpu_uart_num), 3);
    chk("arst_busy", int'(arb_busy), 0);
    cpu_req = 3'b000;
    @(posedge clk);
    #2 rst = 1'b1;
    cpu_req = 3'b111;
    wait_gnt(10, w);
    chk("arst_cpu0_first", int'(cpu_gnt), 3'b001);
    cpu_req = 3'b000;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "global timeout");
  end

endmodule
